multi_debouncer: RTL and testbench
==================================

Name: multi_debouncer

Overview:
- Parametrised, multi-channel successor to the single-input debouncer, for banks of push-buttons and switches.
- Each channel does the following:
  - synchronises its raw pad input into the clk domain;
  - filters bounce with a consecutive-stability counter;
  - emits registered edge pulses and a long-press pulse/flag.
- Sits between the board I/O and the control FSMs, so consumers never need their own edge detection.

Parameters:
- CHANNELS, 4: number of independent input channels (≥1).
- DELAY, 400_000: consecutive clk cycles of stable, differing synchronised input required before the debounced level flips (≥2).
- SYNC_STAGES, 2: flip-flop stages in each input synchroniser (≥2).
- LONG_PRESS, 100_000_000: cycles the debounced level must stay high to flag a long press; 0 disables long-press detection.

Ports:
- clk  input  1  system clock; all state is on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- din  input  CHANNELS  raw asynchronous inputs, active-high.
- level  output  CHANNELS  debounced level.
- rise  output  CHANNELS  one-cycle pulse when level goes 0→1.
- fall  output  CHANNELS  one-cycle pulse when level goes 1→0.
- long_pulse  output  CHANNELS  one-cycle pulse when a long press is first reached.
- long_held  output  CHANNELS  high from long_pulse until the next fall of that channel.

Behaviour:
- Reset is asynchronous and active-low. While rst_n=0, the following are all 0 immediately, and are released on the first posedge after rst_n rises:
  - synchroniser flops, level, stability counter;
  - hold counter, rise, fall, long_pulse, long_held.
- Reset mid-bounce or mid-press discards all progress; the channel restarts from level=0.
- Channels are fully independent; all channel logic is identical.
- Synchroniser: s = din after SYNC_STAGES flops.
- Stability counter:
  - Width = clog2(DELAY+1).
  - If s == level: counter <= 0.
  - If s != level and counter < DELAY-1: counter <= counter+1.
  - If s != level and counter == DELAY-1: level <= s and counter <= 0.
  - Hence level flips on the DELAY-th consecutive mismatching cycle.
  - Any single matching cycle restarts the count (glitch rejection).
- Latency: a clean step on din reaches level after exactly SYNC_STAGES + DELAY clk edges.
- Edge pulses:
  - rise/fall are registered and assert in the same cycle level first shows its new value.
  - They last exactly one cycle and never assert together on one channel.
- Long press (LONG_PRESS > 0):
  - Hold counter (width clog2(LONG_PRESS+1)) counts while level=1 and is cleared to 0 while level=0.
  - When the hold counter == LONG_PRESS-1 and level=1: long_pulse=1 for one cycle, long_held <= 1, and the counter saturates (no further pulses this press).
  - long_held clears in the same cycle fall asserts.
  - A release shorter than DELAY does not clear long_held, because level never falls.
  - long_pulse therefore asserts LONG_PRESS cycles after rise.
- LONG_PRESS = 0: long_pulse and long_held are tied to 0 and the hold counter is not generated.
- Simultaneous events on different channels are all reported in the same cycle.

Decomposition:
- Package debounce_pkg holds:
  - default constants DEFAULT_DELAY, DEFAULT_SYNC_STAGES, DEFAULT_LONG_PRESS;
  - a counter-width helper function (clog2(n+1)).
- Sub-module debounce_channel implements one channel:
  - synchroniser, stability counter, edge pulses, long-press logic.
- multi_debouncer generate-instantiates debounce_channel CHANNELS times.

Test Plan (CHANNELS=2, DELAY=4, SYNC_STAGES=2, LONG_PRESS=10):
- Reset behaviour: drive rst_n=0 with din=2'b11 → all outputs read 0 immediately and asynchronously. Release → level[0] rises 6 clk edges later with a one-cycle rise[0].
- Clean step: din[0] 0→1 held → level[0]=1 and rise[0]=1 at edge 6 only. Then long_pulse[0]=1 at edge 16 for one cycle; long_held[0] stays 1.
- Glitch rejection: din[0] toggles 1,1,1,0 per clk for 20 cycles → level[0] stays 0 with no pulses. Then hold din[0]=1 for 3 cycles → still 0.
- Bounce on release: while long_held[0]=1, drive din[0] 0 for 2 cycles then 1 → level and long_held unchanged. Then hold din[0]=0 → fall[0] and long_held[0]=0 at edge 6 after the final drop.
- Independent channels: step din=2'b11 in the same cycle → rise=2'b11 in the same cycle. Then step din[1] to 0 only → only fall[1] pulses.
- Reset mid-operation: assert rst_n=0 when the stability counter is at 3 → no late flip after release. level reflects din only after a full 6-cycle settle.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared constants and helpers for the multi-channel debouncer.
//   DEFAULT_DELAY        default stability window in clk cycles
//   DEFAULT_SYNC_STAGES  default synchroniser depth
//   DEFAULT_LONG_PRESS   default long-press threshold in clk cycles (0 = off)
//   cnt_width(n)         bits needed to hold values 0..n
package debounce_pkg;

  localparam int DEFAULT_DELAY       = 400_000;
  localparam int DEFAULT_SYNC_STAGES = 2;
  localparam int DEFAULT_LONG_PRESS  = 100_000_000;

  // Width of a counter that must be able to hold the value n.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage : debounce_pkg

// File: rtl/debounce_channel.sv
// One debouncer channel: pad synchroniser, consecutive-stability filter,
// registered edge pulses and optional long-press detection.
// Ports:
//   clk         system clock, all state on posedge
//   rst_n       asynchronous active-low reset
//   din         raw asynchronous input, active-high
//   level       debounced level
//   rise/fall   one-cycle pulses coincident with the first cycle of a new level
//   long_pulse  one-cycle pulse when the level has been high LONG_PRESS cycles
//   long_held   high from long_pulse until the next fall
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int DELAY       = DEFAULT_DELAY,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
  parameter int LONG_PRESS  = DEFAULT_LONG_PRESS
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall,
  output logic long_pulse,
  output logic long_held
);

  localparam int              CW     = cnt_width(DELAY);
  localparam logic [CW-1:0]   C_LAST = CW'(DELAY - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_s;
  logic [CW-1:0]          r_cnt;
  logic [CW-1:0]          w_cnt_nxt;
  logic                   w_flip;
  logic                   w_fall_now;
  logic                   r_level;
  logic                   r_rise;
  logic                   r_fall;

  // Input synchroniser shift register; oldest stage is the filtered sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], din};
    end
  end

  assign w_s = r_sync[SYNC_STAGES-1];

  // Stability counter next state: any matching sample restarts the count,
  // the DELAY-th consecutive mismatch flips the level.
  always_comb begin
    w_flip    = 1'b0;
    w_cnt_nxt = '0;
    if (w_s != r_level) begin
      if (r_cnt == C_LAST) begin
        w_flip    = 1'b1;
        w_cnt_nxt = '0;
      end else begin
        w_flip    = 1'b0;
        w_cnt_nxt = r_cnt + CW'(1);
      end
    end else begin
      w_flip    = 1'b0;
      w_cnt_nxt = '0;
    end
  end

  assign w_fall_now = w_flip & r_level;

  // Level, counter and edge pulses; pulses are set on the same edge as the flip.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_level <= r_level ^ w_flip;
      r_rise  <= w_flip & ~r_level;
      r_fall  <= w_fall_now;
    end
  end

  assign level = r_level;
  assign rise  = r_rise;
  assign fall  = r_fall;

  generate
    if (LONG_PRESS > 0) begin : g_long
      localparam int            HW     = cnt_width(LONG_PRESS);
      localparam logic [HW-1:0] H_LAST = HW'(LONG_PRESS - 1);
      localparam logic [HW-1:0] H_SAT  = HW'(LONG_PRESS);

      logic [HW-1:0] r_hold;
      logic [HW-1:0] w_hold_nxt;
      logic          w_hit;
      logic          r_long_pulse;
      logic          r_long_held;

      // Hold counter saturates at LONG_PRESS so a press fires only once.
      // A hit coinciding with a fall is suppressed so long_held never
      // survives past the release.
      always_comb begin
        w_hold_nxt = r_hold;
        w_hit      = 1'b0;
        if (!r_level) begin
          w_hold_nxt = '0;
          w_hit      = 1'b0;
        end else begin
          if (r_hold != H_SAT) begin
            w_hold_nxt = r_hold + HW'(1);
          end else begin
            w_hold_nxt = r_hold;
          end
          if ((r_hold == H_LAST) && !w_fall_now) begin
            w_hit = 1'b1;
          end else begin
            w_hit = 1'b0;
          end
        end
      end

      // Long-press registers; fall has priority over a new hit.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_hold       <= '0;
          r_long_pulse <= 1'b0;
          r_long_held  <= 1'b0;
        end else begin
          r_hold       <= w_hold_nxt;
          r_long_pulse <= w_hit;
          if (w_fall_now) begin
            r_long_held <= 1'b0;
          end else if (w_hit) begin
            r_long_held <= 1'b1;
          end else begin
            r_long_held <= r_long_held;
          end
        end
      end

      assign long_pulse = r_long_pulse;
      assign long_held  = r_long_held;
    end else begin : g_no_long
      assign long_pulse = 1'b0;
      assign long_held  = 1'b0;
    end
  endgenerate

endmodule : debounce_channel

// File: rtl/multi_debouncer.sv
// Bank of CHANNELS independent debouncers between board I/O and control FSMs.
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   din          raw asynchronous inputs, one bit per channel
//   level        debounced levels
//   rise, fall   one-cycle edge pulses per channel
//   long_pulse   one-cycle long-press pulse per channel
//   long_held    long-press flag per channel, cleared by that channel's fall
module multi_debouncer
  import debounce_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int DELAY       = DEFAULT_DELAY,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
  parameter int LONG_PRESS  = DEFAULT_LONG_PRESS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] din,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic [CHANNELS-1:0] long_pulse,
  output logic [CHANNELS-1:0] long_held
);

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      debounce_channel #(
        .DELAY       (DELAY),
        .SYNC_STAGES (SYNC_STAGES),
        .LONG_PRESS  (LONG_PRESS)
      ) u_ch (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din[gi]),
        .level      (level[gi]),
        .rise       (rise[gi]),
        .fall       (fall[gi]),
        .long_pulse (long_pulse[gi]),
        .long_held  (long_held[gi])
      );
    end
  endgenerate

endmodule : multi_debouncer

// File: tb/tb_multi_debouncer.sv
// Self-checking bench for multi_debouncer (CHANNELS=2, DELAY=4,
// SYNC_STAGES=2, LONG_PRESS=10). A sliding-window reference model predicts
// every output each cycle into a scoreboard queue; tasks also check the
// hand-derived timing points directly.
module tb_multi_debouncer;

  localparam int CH  = 2;
  localparam int DLY = 4;
  localparam int SS  = 2;
  localparam int LP  = 10;

  logic          clk;
  logic          rst_n;
  logic [CH-1:0] din;
  logic [CH-1:0] level;
  logic [CH-1:0] rise;
  logic [CH-1:0] fall;
  logic [CH-1:0] long_pulse;
  logic [CH-1:0] long_held;
  logic [9:0]    w_obs;

  int errors = 0;
  int checks = 0;

  logic [9:0] sb_q[$];
  logic [9:0] exp_v;

  // reference model state
  logic [SS-1:0]  m_sync [CH];
  logic [DLY-1:0] m_win  [CH];
  logic           m_level[CH];
  int             m_age  [CH];
  logic           m_held [CH];

  multi_debouncer #(
    .CHANNELS    (CH),
    .DELAY       (DLY),
    .SYNC_STAGES (SS),
    .LONG_PRESS  (LP)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .level      (level),
    .rise       (rise),
    .fall       (fall),
    .long_pulse (long_pulse),
    .long_held  (long_held)
  );

  assign w_obs = {level, rise, fall, long_pulse, long_held};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_sync[c]  = '0;
      m_win[c]   = '0;
      m_level[c] = 1'b0;
      m_age[c]   = 0;
      m_held[c]  = 1'b0;
    end
    sb_q.delete();
  endtask

  // Predict outputs after the coming posedge: level flips once the last DLY
  // synchronised samples all disagree with it; long press fires LP edges
  // after the rise.
  task automatic model_push(input logic [CH-1:0] d);
    logic [CH-1:0] e_lv, e_ri, e_fa, e_lp, e_lh;
    logic s, flip;
    for (int c = 0; c < CH; c++) begin
      s         = m_sync[c][SS-1];
      m_sync[c] = {m_sync[c][SS-2:0], d[c]};
      m_win[c]  = {m_win[c][DLY-2:0], s};
      flip      = (m_win[c] == {DLY{~m_level[c]}});
      e_ri[c]   = flip & ~m_level[c];
      e_fa[c]   = flip & m_level[c];
      e_lp[c]   = 1'b0;
      if (flip) begin
        if (m_level[c]) m_held[c] = 1'b0;
        m_level[c] = ~m_level[c];
        m_age[c]   = 0;
      end else if (m_level[c]) begin
        m_age[c] = m_age[c] + 1;
        if (m_age[c] == LP) begin
          e_lp[c]   = 1'b1;
          m_held[c] = 1'b1;
        end
      end
      e_lv[c] = m_level[c];
      e_lh[c] = m_held[c];
    end
    sb_q.push_back({e_lv, e_ri, e_fa, e_lp, e_lh});
  endtask

  // Drive one cycle of stimulus and advance to the following negedge.
  task automatic run_cycle(input logic [CH-1:0] d);
    din = d;
    model_push(d);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset(input logic [CH-1:0] d);
    rst_n = 1'b0;
    din   = d;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    din   = 2'b11;
    #1;
    checks++;
    if (w_obs !== 10'b0) begin
      errors++;
      $display("FAIL reset_async: outputs=%b expected all zero", w_obs);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 8; i++) begin
      run_cycle(2'b11);
      exp_v = sb_q.pop_front();
      checks++;
      if (w_obs !== exp_v) begin
        errors++;
        $display("FAIL reset_seq cyc=%0d: obs=%b exp=%b", i, w_obs, exp_v);
      end
      if (i == 4) begin
        checks++;
        if (level[0] !== 1'b0) begin
          errors++;
          $display("FAIL reset_early: level0=%b expected 0 at edge 5", level[0]);
        end
      end
      if (i == 5) begin
        checks++;
        if ({level[0], rise[0]} !== 2'b11) begin
          errors++;
          $display("FAIL reset_rise: level0/rise0=%b%b expected 11 at edge 6", level[0], rise[0]);
        end
      end
    end
  endtask

  task automatic test_clean_step();
    apply_reset(2'b00);
    for (int i = 0; i < 22; i++) begin
      run_cycle((i < 2) ? 2'b00 : 2'b01);
      exp_v = sb_q.pop_front();
      checks++;
      if (w_obs !== exp_v) begin
        errors++;
        $display("FAIL clean_seq cyc=%0d: obs=%b exp=%b", i, w_obs, exp_v);
      end
      if (i == 7) begin
        checks++;
        if ({level[0], rise[0]} !== 2'b11) begin
          errors++;
          $display("FAIL clean_rise: level0/rise0=%b%b expected 11", level[0], rise[0]);
        end
      end
      if (i == 17) begin
        checks++;
        if ({long_pulse[0], long_held[0]} !== 2'b11) begin
          errors++;
          $display("FAIL clean_long: pulse/held=%b%b expected 11 at edge 16", long_pulse[0], long_held[0]);
        end
      end
    end
    checks++;
    if ({long_pulse[0], long_held[0], level[0]} !== 3'b011) begin
      errors++;
      $display("FAIL clean_hold: pulse/held/level=%b%b%b expected 011", long_pulse[0], long_held[0], level[0]);
    end
  endtask

  task automatic test_glitch();
    logic [CH-1:0] d;
    apply_reset(2'b00);
    for (int i = 0; i < 29; i++) begin
      if (i < 20)      d = {1'b0, (i % 4) != 3};
      else if (i < 23) d = 2'b01;
      else             d = 2'b00;
      run_cycle(d);
      exp_v = sb_q.pop_front();
      checks++;
      if (w_obs !== exp_v) begin
        errors++;
        $display("FAIL glitch_seq cyc=%0d: obs=%b exp=%b", i, w_obs, exp_v);
      end
      checks++;
      if ({level[0], rise[0], fall[0]} !== 3'b000) begin
        errors++;
        $display("FAIL glitch_level cyc=%0d: level/rise/fall=%b%b%b expected 000", i, level[0], rise[0], fall[0]);
      end
    end
  endtask

  task automatic test_bounce_release();
    logic [CH-1:0] d;
    apply_reset(2'b00);
    for (int i = 0; i < 28; i++) begin
      if (i < 20)      d = 2'b01;
      else if (i < 22) d = 2'b00;
      else             d = 2'b01;
      run_cycle(d);
      exp_v = sb_q.pop_front();
      checks++;
      if (w_obs !== exp_v) begin
        errors++;
        $display("FAIL bounce_seq cyc=%0d: obs=%b exp=%b", i, w_obs, exp_v);
      end
    end
    checks++;
    if ({level[0], long_held[0], fall[0]} !== 3'b110) begin
      errors++;
      $display("FAIL bounce_keep: level/held/fall=%b%b%b expected 110", level[0], long_held[0], fall[0]);
    end
    for (int i = 0; i < 8; i++) begin
      run_cycle(2'b00);
      exp_v = sb_q.pop_front();
      checks++;
      if (w_obs !== exp_v) begin
        errors++;
        $display("FAIL release_seq cyc=%0d: obs=%b exp=%b", i, w_obs, exp_v);
      end
      if (i == 4) begin
        checks++;
        if ({level[0], long_held[0]} !== 2'b11) begin
          errors++;
          $display("FAIL release_early: level/held=%b%b expected 11", level[0], long_held[0]);
        end
      end
      if (i == 5) begin
        checks++;
        if ({level[0], fall[0], long_held[0]} !== 3'b010) begin
          errors++;
          $display("FAIL release_fall: level/fall/held=%b%b%b expected 010", level[0], fall[0], long_held[0]);
        end
      end
    end
  endtask

  task automatic test_independent();
    apply_reset(2'b00);
    for (int i = 0; i < 16; i++) begin
      run_cycle((i < 8) ? 2'b11 : 2'b01);
      exp_v = sb_q.pop_front();
      checks++;
      if (w_obs !== exp_v) begin
        errors++;
        $display("FAIL indep_seq cyc=%0d: obs=%b exp=%b", i, w_obs, exp_v);
      end
      if (i == 5) begin
        checks++;
        if ({rise, level} !== 4'b1111) begin
          errors++;
          $display("FAIL indep_rise: rise=%b level=%b expected 11/11", rise, level);
        end
      end
      if (i == 13) begin
        checks++;
        if ({fall, rise, level} !== 6'b100001) begin
          errors++;
          $display("FAIL indep_fall: fall=%b rise=%b level=%b expected 10/00/01", fall, rise, level);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    apply_reset(2'b00);
    for (int i = 0; i < 5; i++) begin
      run_cycle(2'b01);
      exp_v = sb_q.pop_front();
      checks++;
      if (w_obs !== exp_v) begin
        errors++;
        $display("FAIL midrst_pre cyc=%0d: obs=%b exp=%b", i, w_obs, exp_v);
      end
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (w_obs !== 10'b0) begin
      errors++;
      $display("FAIL midrst_async: outputs=%b expected all zero", w_obs);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 8; i++) begin
      run_cycle(2'b01);
      exp_v = sb_q.pop_front();
      checks++;
      if (w_obs !== exp_v) begin
        errors++;
        $display("FAIL midrst_seq cyc=%0d: obs=%b exp=%b", i, w_obs, exp_v);
      end
      if (i == 4) begin
        checks++;
        if (level[0] !== 1'b0) begin
          errors++;
          $display("FAIL midrst_early: level0=%b expected 0", level[0]);
        end
      end
      if (i == 5) begin
        checks++;
        if ({level[0], rise[0]} !== 2'b11) begin
          errors++;
          $display("FAIL midrst_settle: level0/rise0=%b%b expected 11", level[0], rise[0]);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    din   = '0;
    model_reset();
    test_reset();
    test_clean_step();
    test_glitch();
    test_bounce_release();
    test_independent();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_multi_debouncer
